// File: rtl/writeback_arbiter_stage_pkg.sv
// Shared types and defaults for the multi-channel writeback stage.
// Holds the register/word types, the per-channel entry layout and the default sizes.
// Types only: no timing and no flow control live here.
package writeback_arbiter_stage_pkg;

    localparam int REG_W             = 5;
    localparam int WB_NUM_CH_DEFAULT = 2;
    localparam int WB_DEPTH_DEFAULT  = 2;

    typedef logic [REG_W-1:0] rvga_reg;
    typedef logic [31:0]      rvga_word;

    typedef struct packed {
        rvga_reg  rd;
        rvga_word result;
        logic     rd_w_v;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_stage_if.sv
// Producer and consumer bundle of the writeback stage: per-channel push handshakes plus the retire port.
// No logic and no latency; the master side drives producers and stall, the slave side is the stage.
// Backpressure is ch_ready per channel towards producers and writeback_stall from the consumer.
interface writeback_arbiter_stage_if
    import writeback_arbiter_stage_pkg::*;
#(
    parameter int NUM_CH = WB_NUM_CH_DEFAULT,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 32
);
    logic [NUM_CH-1:0]       ch_v;
    logic [NUM_CH-1:0]       ch_ready;
    logic [NUM_CH*REG_W-1:0] ch_rd;
    logic [NUM_CH*XLEN-1:0]  ch_result;
    logic [NUM_CH-1:0]       ch_rd_w_v;
    logic                    writeback_stall;
    logic [REG_W-1:0]        writeback_rfetch_rd;
    logic [XLEN-1:0]         writeback_rfetch_rd_data;
    logic                    writeback_rfetch_rd_w_v;
    logic [XLEN-1:0]         writeback_ifetch_pc_target;
    logic                    writeback_ifetch_pc_v;
    logic [CNT_W-1:0]        retire_count;

    modport master (
        output ch_v, ch_rd, ch_result, ch_rd_w_v, writeback_stall,
        input  ch_ready, writeback_rfetch_rd, writeback_rfetch_rd_data, writeback_rfetch_rd_w_v,
        input  writeback_ifetch_pc_target, writeback_ifetch_pc_v, retire_count
    );

    modport slave (
        input  ch_v, ch_rd, ch_result, ch_rd_w_v, writeback_stall,
        output ch_ready, writeback_rfetch_rd, writeback_rfetch_rd_data, writeback_rfetch_rd_w_v,
        output writeback_ifetch_pc_target, writeback_ifetch_pc_v, retire_count
    );

endinterface

// File: rtl/writeback_arbiter_stage_wb_chan_fifo.sv
// Per-channel circular-buffer FIFO; the extra wrap bit on the pointers separates full from empty.
// Push is visible at pop_data one cycle after the push edge; there is no bypass.
// Pushes are dropped while full and pops are ignored while empty; the caller gates both.
module wb_chan_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_v,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_v && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)   rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_v && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter_stage.sv
// Round-robin retire of NUM_CH producer FIFOs onto one register write port and the PC-redirect path.
// Two cycles minimum from push to retire outputs; ch_ready tracks FIFO occupancy only.
// writeback_stall freezes pops, rr pointer, output registers and the retire counter.
module writeback_arbiter_stage
    import writeback_arbiter_stage_pkg::*;
#(
    parameter int NUM_CH = WB_NUM_CH_DEFAULT,
    parameter int DEPTH  = WB_DEPTH_DEFAULT,
    parameter int XLEN   = 32,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    writeback_arbiter_stage_if.slave bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef struct packed {
        rvga_reg         rd;
        logic [XLEN-1:0] result;
        logic            rd_w_v;
    } entry_t;

    entry_t            push_dat [NUM_CH];
    entry_t            pop_dat  [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] push_v;

    logic [CW-1:0]     rr_ptr;
    logic [CW-1:0]     gnt;
    logic              gnt_vld;
    logic              retire;
    int                idx;
    entry_t            sel;

    logic [REG_W-1:0]  rd_q;
    logic [XLEN-1:0]   rd_data_q;
    logic              rd_w_v_q;
    logic [XLEN-1:0]   pc_target_q;
    logic              pc_v_q;
    logic [CNT_W-1:0]  cnt_q;

    assign bus.ch_ready = ~full & {NUM_CH{!rst}};
    assign push_v       = bus.ch_v & bus.ch_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign push_dat[i] = '{rd:     bus.ch_rd[i*REG_W +: REG_W],
                               result: bus.ch_result[i*XLEN +: XLEN],
                               rd_w_v: bus.ch_rd_w_v[i]};

        wb_chan_fifo #(
            .DEPTH   (DEPTH),
            .entry_t (entry_t)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push_v    (push_v[i]),
            .push_data (push_dat[i]),
            .pop       (pop[i]),
            .pop_data  (pop_dat[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // Scan starts one past the last winner so every channel gets a turn.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!gnt_vld && !empty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = CW'(idx);
            end
        end
    end

    assign retire = gnt_vld && !bus.writeback_stall;
    assign sel    = pop_dat[gnt];

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) pop[i] = retire && (gnt == CW'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= CW'(NUM_CH - 1);
            rd_q        <= '0;
            rd_data_q   <= '0;
            rd_w_v_q    <= 1'b0;
            pc_target_q <= '0;
            pc_v_q      <= 1'b0;
            cnt_q       <= '0;
        end else if (!bus.writeback_stall) begin
            if (gnt_vld) begin
                rr_ptr      <= gnt;
                rd_q        <= sel.rd;
                rd_data_q   <= sel.result;
                pc_target_q <= sel.result;
                pc_v_q      <= 1'b1;
                // x0 still retires and redirects, it just never writes the register file.
                rd_w_v_q    <= sel.rd_w_v && (sel.rd != '0);
                cnt_q       <= cnt_q + CNT_W'(1);
            end else begin
                pc_v_q      <= 1'b0;
                rd_w_v_q    <= 1'b0;
            end
        end
    end

    assign bus.writeback_rfetch_rd        = rd_q;
    assign bus.writeback_rfetch_rd_data   = rd_data_q;
    assign bus.writeback_rfetch_rd_w_v    = rd_w_v_q;
    assign bus.writeback_ifetch_pc_target = pc_target_q;
    assign bus.writeback_ifetch_pc_v      = pc_v_q;
    assign bus.retire_count               = cnt_q;

endmodule

// File: tb/tb_writeback_arbiter_stage.sv
// Bench for writeback_arbiter_stage: directed scenarios then random traffic against a queue-based model.
module tb_writeback_arbiter_stage;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 2;
    localparam int XLEN   = 32;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] res;
        logic        wv;
    } ent_t;

    logic clk;
    logic rst;
    logic stall;
    logic [NUM_CH-1:0] offer;
    int total;
    int bad;

    ent_t src [NUM_CH][$];
    ent_t q   [NUM_CH][$];
    int   m_rr;
    int   m_cnt;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [31:0] m_pc;
    logic        m_pcv;
    logic        m_wv;

    writeback_arbiter_stage_if #(.NUM_CH(NUM_CH), .XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    writeback_arbiter_stage #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mk(logic [4:0] rd, logic [31:0] res, logic wv);
        ent_t e;
        e.rd  = rd;
        e.res = res;
        e.wv  = wv;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk(5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)));
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive producers, check ready, advance the model, then check the retire port.
    task automatic tick();
        logic [NUM_CH-1:0] v;
        logic [NUM_CH-1:0] rdy;
        int g;
        int c;
        ent_t e;
        for (int i = 0; i < NUM_CH; i++) begin
            v[i] = (src[i].size() > 0) && offer[i];
            bus.ch_v[i] = v[i];
            if (src[i].size() > 0) e = src[i][0];
            else                   e = rnd_ent();
            bus.ch_rd[i*5 +: 5]         = e.rd;
            bus.ch_result[i*32 +: 32]   = e.res;
            bus.ch_rd_w_v[i]            = e.wv;
        end
        bus.writeback_stall = stall;
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            rdy[i] = !rst && (q[i].size() < DEPTH);
            chk("ch_ready", 64'(bus.ch_ready[i]), 64'(rdy[i]));
        end
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) q[i].delete();
            m_rr = NUM_CH - 1; m_cnt = 0;
            m_rd = '0; m_data = '0; m_pc = '0; m_pcv = 1'b0; m_wv = 1'b0;
        end else begin
            if (!stall) begin
                g = -1;
                for (int k = 1; k <= NUM_CH; k++) begin
                    c = (m_rr + k) % NUM_CH;
                    if (g < 0 && q[c].size() > 0) g = c;
                end
                if (g >= 0) begin
                    e = q[g].pop_front();
                    m_rd = e.rd; m_data = e.res; m_pc = e.res; m_pcv = 1'b1;
                    m_wv = e.wv && (e.rd != 0);
                    m_rr = g;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                end else begin
                    m_pcv = 1'b0; m_wv = 1'b0;
                end
            end
            for (int i = 0; i < NUM_CH; i++)
                if (v[i] && rdy[i]) q[i].push_back(src[i].pop_front());
        end
        @(posedge clk);
        #1;
        chk("rd",        64'(bus.writeback_rfetch_rd),        64'(m_rd));
        chk("rd_data",   64'(bus.writeback_rfetch_rd_data),   64'(m_data));
        chk("rd_w_v",    64'(bus.writeback_rfetch_rd_w_v),    64'(m_wv));
        chk("pc_target", 64'(bus.writeback_ifetch_pc_target), 64'(m_pc));
        chk("pc_v",      64'(bus.writeback_ifetch_pc_v),      64'(m_pcv));
        chk("count",     64'(bus.retire_count),               64'(m_cnt));
    endtask

    function automatic bit busy();
        for (int i = 0; i < NUM_CH; i++)
            if (src[i].size() > 0 || q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    logic [31:0] exp_rr [4];

    initial begin
        total = 0; bad = 0;
        m_rr = NUM_CH - 1; m_cnt = 0;
        m_rd = '0; m_data = '0; m_pc = '0; m_pcv = 1'b0; m_wv = 1'b0;
        bus.ch_v = '0; bus.ch_rd = '0; bus.ch_result = '0; bus.ch_rd_w_v = '0;
        bus.writeback_stall = 1'b0;
        offer = '1;
        stall = 1'b0;
        rst   = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset mid-stream discards queued entries.
        stall = 1'b1;
        src[0].push_back(mk(5'd3, 32'h0000_0303, 1'b1));
        src[0].push_back(mk(5'd4, 32'h0000_0404, 1'b1));
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.ch_ready), 64'(2'b11));
        tick(); tick();
        chk("rst_no_stale_pcv", 64'(bus.writeback_ifetch_pc_v), 64'd0);
        chk("rst_no_stale_cnt", 64'(bus.retire_count), 64'd0);

        // Single entry, two-cycle latency.
        src[0].push_back(mk(5'd5, 32'hDEAD_BEEF, 1'b1));
        tick();
        chk("lat_early_pcv", 64'(bus.writeback_ifetch_pc_v), 64'd0);
        tick();
        chk("single_rd",   64'(bus.writeback_rfetch_rd), 64'd5);
        chk("single_data", 64'(bus.writeback_rfetch_rd_data), 64'hDEAD_BEEF);
        chk("single_wv",   64'(bus.writeback_rfetch_rd_w_v), 64'd1);
        chk("single_pc",   64'(bus.writeback_ifetch_pc_target), 64'hDEAD_BEEF);
        chk("single_pcv",  64'(bus.writeback_ifetch_pc_v), 64'd1);
        chk("single_cnt",  64'(bus.retire_count), 64'd1);
        tick();

        // Round robin A0,B0,A1,B1 from a fresh reset.
        rst = 1'b1; tick(); rst = 1'b0;
        exp_rr[0] = 32'hA000_0000; exp_rr[1] = 32'hB000_0000;
        exp_rr[2] = 32'hA000_0001; exp_rr[3] = 32'hB000_0001;
        stall = 1'b1;
        src[0].push_back(mk(5'd10, exp_rr[0], 1'b1));
        src[0].push_back(mk(5'd11, exp_rr[2], 1'b1));
        src[1].push_back(mk(5'd20, exp_rr[1], 1'b1));
        src[1].push_back(mk(5'd21, exp_rr[3], 1'b1));
        tick(); tick();
        stall = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rr_order", 64'(bus.writeback_rfetch_rd_data), 64'(exp_rr[j]));
        end
        chk("rr_cnt", 64'(bus.retire_count), 64'd4);

        // Backpressure on ch1 while stalled.
        stall = 1'b1;
        src[1].push_back(mk(5'd12, 32'hC000_0000, 1'b1));
        src[1].push_back(mk(5'd13, 32'hC000_0001, 1'b1));
        src[1].push_back(mk(5'd14, 32'hC000_0002, 1'b1));
        tick(); tick();
        chk("bp_ready_low", 64'(bus.ch_ready[1]), 64'd0);
        tick(); tick();
        stall = 1'b0;
        tick();
        chk("bp_ready_back", 64'(bus.ch_ready[1]), 64'd1);
        for (int j = 0; j < 4; j++) tick();

        // Stall holds a visible retire.
        stall = 1'b1;
        src[0].push_back(mk(5'd7, 32'h0000_0077, 1'b1));
        src[0].push_back(mk(5'd9, 32'h0000_0099, 1'b1));
        tick(); tick();
        stall = 1'b0;
        tick();
        chk("hold_rd7", 64'(bus.writeback_rfetch_rd), 64'd7);
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("hold_rd", 64'(bus.writeback_rfetch_rd), 64'd7);
            chk("hold_pcv", 64'(bus.writeback_ifetch_pc_v), 64'd1);
        end
        stall = 1'b0;
        tick();
        chk("hold_next_rd", 64'(bus.writeback_rfetch_rd), 64'd9);
        tick();

        // x0 retire and counter wrap: 17 retires from reset land on 1.
        rst = 1'b1; tick(); rst = 1'b0;
        src[0].push_back(mk(5'd0, 32'h0000_1234, 1'b1));
        tick(); tick();
        chk("x0_pcv", 64'(bus.writeback_ifetch_pc_v), 64'd1);
        chk("x0_wv",  64'(bus.writeback_rfetch_rd_w_v), 64'd0);
        chk("x0_cnt", 64'(bus.retire_count), 64'd1);
        for (int j = 0; j < 16; j++) src[$urandom_range(0, NUM_CH-1)].push_back(rnd_ent());
        for (int j = 0; j < 60 && busy(); j++) tick();
        chk("wrap_drained", 64'(busy()), 64'd0);
        tick();
        chk("wrap_cnt", 64'(bus.retire_count), 64'd1);

        // Random traffic with stalls, gaps and occasional reset.
        for (int j = 0; j < 500; j++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (src[i].size() < 3 && $urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 15) == 0) src[i].push_back(mk(5'd0, $urandom, 1'b1));
                    else                            src[i].push_back(rnd_ent());
                end
                offer[i] = ($urandom_range(0, 3) != 0);
            end
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; stall = 1'b0; offer = '1;
        for (int j = 0; j < 100 && busy(); j++) tick();
        chk("final_drained", 64'(busy()), 64'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter_stage.md
Name: writeback_arbiter_stage

Overview:
- Parametrised multi-channel writeback stage that retires results from NUM_CH producers, e.g. the memory stage and a long-latency multiply/divide unit.
- Each producer channel has a valid/ready handshake into a DEPTH-entry FIFO.
- A round-robin arbiter retires at most one entry per cycle onto the single register-fetch write port and the ifetch PC-target path.
- Adds over the single-channel stage: backpressure, stall, x0 write suppression and a retire counter.

Parameters:
- NUM_CH, 2, number of producer channels (1..8).
- DEPTH, 2, entries per channel FIFO (power of two, >=2).
- XLEN, 32, result width (matches rvga_word).
- CNT_W, 32, retire counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ch_v  in  NUM_CH  channel i offers an entry.
- ch_ready  out  NUM_CH  channel i FIFO not full.
- ch_rd  in  NUM_CH*5  destination register per channel.
- ch_result  in  NUM_CH*XLEN  result per channel.
- ch_rd_w_v  in  NUM_CH  entry requests a register write.
- writeback_stall  in  1  register-fetch cannot accept a retire this cycle.
- writeback_rfetch_rd  out  5  retired destination register.
- writeback_rfetch_rd_data  out  XLEN  retired data.
- writeback_rfetch_rd_w_v  out  1  register write strobe.
- writeback_ifetch_pc_target  out  XLEN  retired result, used as redirect target.
- writeback_ifetch_pc_v  out  1  retire pulse qualifying pc_target.
- retire_count  out  CNT_W  number of entries retired since reset.

Behaviour:
- Reset: rst=1 at posedge clears all FIFOs, rr_ptr=NUM_CH-1, every output register and retire_count to 0.
  - ch_ready is 0 while rst is high.
  - Reset mid-operation discards all queued entries.
- Push:
  - ch_ready[i] = !full[i]; combinational from FIFO count only, never from pop or stall.
  - Entry {rd, result, rd_w_v} is written when ch_v[i] & ch_ready[i].
  - ch_v with ch_ready=0 is ignored; the producer must hold.
- Arbitration, when writeback_stall=0:
  - grant = first non-empty channel scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_CH.
  - The granted channel pops and rr_ptr <= grant.
  - No non-empty channel: no pop and rr_ptr holds.
- Output registers, updated only when writeback_stall=0:
  - On a grant: rd <= entry.rd; rd_data <= entry.result; pc_target <= entry.result; pc_v <= 1; rd_w_v <= entry.rd_w_v & (entry.rd != 0).
  - No grant: pc_v <= 0 and rd_w_v <= 0; rd, rd_data and pc_target hold.
- Stall (writeback_stall=1):
  - No pop; rr_ptr and all output registers hold (strobes included).
  - The consumer accepts the held retire in the first cycle with stall=0.
  - Pushes continue while not full.
- Latency:
  - Entry pushed at edge N into an empty system appears on outputs after edge N+1 (2-cycle min).
  - There is no bypass path.
- Simultaneous push and pop on the same FIFO: count unchanged, order preserved.
  - A full FIFO cannot push; ready is deasserted before the pop.
- x0: a write to rd=0 still retires (pc_v=1, counter increments), but rd_w_v=0.
- retire_count increments by 1 on every grant, wraps modulo 2^CNT_W, and holds under stall.
- Per-channel order is strict FIFO. No ordering is guaranteed across channels; producers are responsible for hazards.

Decomposition:
- rvga_types gains wb_entry_t struct {rvga_reg rd; rvga_word result; logic rd_w_v}.
- rvga_defines gains WB_NUM_CH_DEFAULT and WB_DEPTH_DEFAULT.
- Sub-module wb_chan_fifo (DEPTH, entry type):
  - ports push_v, push_data, pop, pop_data, full, empty.
  - Implementation: circular buffer with log2(DEPTH)+1 pointers, so full and empty are distinguished by the wrap bit.
- Instantiated NUM_CH times via generate. The arbiter and output registers live in the top module.

Test Plan:
- Reset mid-stream: fill ch0 with 2 entries, assert rst one cycle -> all outputs 0, ch_ready=0 during reset, 2'b11 after, no stale retire.
- Single entry: ch0 push rd=5, result=0xDEADBEEF, rd_w_v=1 at edge N -> after edge N+1: rd=5, data=0xDEADBEEF, rd_w_v=1, pc_target=0xDEADBEEF, pc_v=1; retire_count=1.
- Round-robin: both channels hold 2 entries (A0,A1 / B0,B1), no stall -> retire order A0,B0,A1,B1 on 4 consecutive cycles; retire_count=4.
- Backpressure: DEPTH=2, ch1 pushes 3 back-to-back with stall=1 -> ch_ready[1]=0 after 2 pushes; 3rd held by producer and accepted the cycle after stall drops.
- Stall hold: retire rd=7 visible, stall=1 for 3 cycles -> outputs and retire_count unchanged; stall=0 -> next entry retires next edge.
- x0 and wrap: CNT_W=4, retire 17 entries incl. one rd=0 -> that retire has rd_w_v=0, pc_v=1; final retire_count=1.
